pipe_collision_score: RTL

- Consumes the two pipe-mover outputs (PipePosXA/YA, PipePosXB/YB) and the bird's vertical position.
- Each cycle it decides whether the bird has struck a pipe or the floor, and raises Lost once a debounced collision is confirmed.
- Counts pipes cleared as a 3-digit BCD score for the display stage; optionally keeps a session high score.

---
 rtl/pipe_collision_score.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/pipe_collision_score.sv
// pipe_collision_score: collision detection, debounced game-over and BCD scoring for the
// bird-and-pipes game. Optional session high score enabled by PIPE_SCORE_HIGH_SCORE_EN.
module pipe_collision_score #(
    parameter int unsigned BIRD_X     = 200,
    parameter int unsigned BIRD_SZ    = 20,
    parameter int unsigned PIPE_W     = 50,
    parameter int unsigned GAP_H      = 150,
    parameter int unsigned FLOOR_Y    = 460,
    parameter int unsigned HIT_CYCLES = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [9:0]  BirdPosY,
    input  logic [9:0]  PipePosXA,
    input  logic [9:0]  PipePosYA,
    input  logic [9:0]  PipePosXB,
    input  logic [9:0]  PipePosYB,
    output logic        Lost,
    output logic [11:0] Score,
    output logic        ScoreTick,
    output logic [11:0] HighScore
);

    localparam logic [10:0] BirdXW     = 11'(BIRD_X);
    localparam logic [10:0] BirdRightW = 11'(BIRD_X + BIRD_SZ);
    localparam logic [10:0] BirdSzW    = 11'(BIRD_SZ);
    localparam logic [10:0] PipeWW     = 11'(PIPE_W);
    localparam logic [10:0] GapHW      = 11'(GAP_H);
    localparam logic [10:0] FloorYW    = 11'(FLOOR_Y);
    localparam logic [3:0]  HitMax     = 4'(HIT_CYCLES);

    typedef enum logic [2:0] {
        StIdle = 3'b001,
        StPlay = 3'b010,
        StLost = 3'b100
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [11:0] score_q, score_d;
    logic        tick_q;
    logic        ahead_qa, ahead_qb;

    logic [10:0] bird_y, bird_bot;
    logic        ahead_a, ahead_b, hit_a, hit_b, hit;
    logic        pass_a, pass_b, confirm;
    logic [11:0] score_p1, score_inc;

    // BCD +1 with per-digit carry, saturating at 999
    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (v != 12'h999) begin
            if (v[3:0] == 4'd9) begin
                r[3:0] = 4'd0;
                if (v[7:4] == 4'd9) begin
                    r[7:4]  = 4'd0;
                    r[11:8] = v[11:8] + 4'd1;
                end else begin
                    r[7:4] = v[7:4] + 4'd1;
                end
            end else begin
                r[3:0] = v[3:0] + 4'd1;
            end
        end
        return r;
    endfunction

    // Geometry: 11-bit unsigned sums so an offscreen X of 1023 never wraps
    always_comb begin
        bird_y   = {1'b0, BirdPosY};
        bird_bot = bird_y + BirdSzW;
        ahead_a  = ({1'b0, PipePosXA} + PipeWW) > BirdXW;
        ahead_b  = ({1'b0, PipePosXB} + PipeWW) > BirdXW;
        hit_a    = ahead_a && ({1'b0, PipePosXA} < BirdRightW) &&
                   ((bird_y < {1'b0, PipePosYA}) || (bird_bot > ({1'b0, PipePosYA} + GapHW)));
        hit_b    = ahead_b && ({1'b0, PipePosXB} < BirdRightW) &&
                   ((bird_y < {1'b0, PipePosYB}) || (bird_bot > ({1'b0, PipePosYB} + GapHW)));
        hit      = hit_a || hit_b || (bird_bot > FloorYW);
        // Only a 1->0 fall of Ahead scores; a reload to large X rises and is ignored
        pass_a    = ahead_qa && !ahead_a;
        pass_b    = ahead_qb && !ahead_b;
        score_p1  = pass_a ? bcd_inc(score_q) : score_q;
        score_inc = pass_b ? bcd_inc(score_p1) : score_p1;
        confirm   = hit && ((cnt_q + 4'd1) >= HitMax);
    end

    // Next state, hit counter and score
    always_comb begin
        state_d = state_q;
        cnt_d   = 4'd0;
        score_d = score_q;
        unique case (state_q)
            StIdle: begin
                score_d = 12'h000;
                if (Start) state_d = StPlay;
            end
            StPlay: begin
                if (!Start) begin
                    state_d = StIdle;
                    score_d = 12'h000;
                end else begin
                    if (hit) cnt_d = confirm ? HitMax : cnt_q + 4'd1;
                    if (confirm) state_d = StLost;
                    else         score_d = score_inc;
                end
            end
            StLost: begin
                if (!Start) begin
                    state_d = StIdle;
                    score_d = 12'h000;
                end
            end
            default: begin
                state_d = StIdle;
                score_d = 12'h000;
            end
        endcase
    end

    // State, counter, score, tick and pass-tracking registers
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= StIdle;
            cnt_q    <= 4'd0;
            score_q  <= 12'h000;
            tick_q   <= 1'b0;
            ahead_qa <= 1'b1;
            ahead_qb <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            score_q  <= score_d;
            tick_q   <= (score_d != score_q);
            ahead_qa <= ahead_a;
            ahead_qb <= ahead_b;
        end
    end

`ifdef PIPE_SCORE_HIGH_SCORE_EN
    logic        enter_lost;
    logic [11:0] high_q;

    assign enter_lost = (state_q == StPlay) && Start && confirm;

    // Session best, captured on entry to LOST; valid BCD compares like binary
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            high_q <= 12'h000;
        end else if (enter_lost && (score_q > high_q)) begin
            high_q <= score_q;
        end
    end

    assign HighScore = high_q;
`else
    assign HighScore = 12'h000;
`endif

    assign Lost      = (state_q == StLost);
    assign Score     = score_q;
    assign ScoreTick = tick_q;

endmodule
